fpga_uart_conditioner: RTL and testbench
========================================

FPGA_UART_CONDITIONER -- requirements
Module: fpga_uart_conditioner

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3: consecutive stable samples required to accept a new RX level; legal range 1..16.
REQ-002 SHALL have parameter BREAK_CYCLES, default 8192: consecutive cycles of filtered RX low that constitute a break; legal range 2..2^20.
REQ-003 SHALL have parameter STRETCH_CYCLES, default 4194304: activity LED on-time in cycles; legal range 1..2^24.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port pad_rx  input  1  raw UART RX from the board pin, asynchronous to clk.
REQ-007 SHALL have port soc_rx  output  1  synchronised, glitch-filtered RX to the SoC UART.
REQ-008 SHALL have port soc_tx  input  1  UART TX from the SoC.
REQ-009 SHALL have port pad_tx  output  1  registered UART TX to the board pin.
REQ-010 SHALL have port break_det  output  1  level; high while a line break is present on filtered RX.
REQ-011 SHALL have port rx_led  output  1  stretched RX activity indicator.
REQ-012 SHALL have port tx_led  output  1  stretched TX activity indicator.
REQ-013 SHALL have port glitch_count  output  8  saturating count of rejected RX glitches.

Function
REQ-014 SHALL pass pad_rx through a 2-flop synchroniser (s1, s2); filtering uses s2 only.
REQ-015 SHALL keep a filter counter: cleared on any cycle where s2 == soc_rx; incremented where s2 != soc_rx.
REQ-016 SHALL toggle soc_rx and clear the counter at the edge where s2 has differed from soc_rx for FILTER_LEN consecutive samples; with the pad sampling edge counted as edge 1, soc_rx changes on edge FILTER_LEN+2.
REQ-017 SHALL treat a return of s2 to soc_rx while the filter counter is nonzero as a glitch: glitch_count increments by 1, saturating at 255, no wrap.
REQ-018 SHALL, when FILTER_LEN = 1, accept any single differing s2 sample; glitch_count then never increments.
REQ-019 SHALL register soc_tx into pad_tx with 1-cycle latency; no filtering on TX.
REQ-020 SHALL keep a break counter counting cycles with soc_rx = 0, saturating at BREAK_CYCLES, cleared on any cycle with soc_rx = 1.
REQ-021 SHALL assert break_det the cycle after the break counter reaches BREAK_CYCLES, and deassert it the cycle after soc_rx returns to 1.
REQ-022 SHALL reload the RX stretch counter to STRETCH_CYCLES on each soc_rx falling edge (start bit), else decrement to 0 and hold; rx_led = (counter != 0), registered.
REQ-023 SHALL drive tx_led identically from falling edges of pad_tx, using a separate counter.
REQ-024 SHALL give a reload priority over a decrement in the same cycle; a falling edge while counting restarts the full STRETCH_CYCLES period.
REQ-025 SHALL size each counter to the minimum width that holds its parameter maximum, with no overflow at any legal parameter value.

Reset
REQ-026 SHALL, while rst_n = 0, immediately force: s1, s2, soc_rx, pad_tx = 1 (line idle); break_det, rx_led, tx_led = 0; glitch_count and all counters = 0.
REQ-027 SHALL treat a reset asserted mid-filter, mid-break or mid-stretch as abandoning that operation; no glitch or edge is counted from the reset transition itself.
REQ-028 SHALL, on first release of rst_n with pad_rx = 1 and soc_tx = 1, produce no edge, LED pulse or glitch count.

Verification (FILTER_LEN=3, BREAK_CYCLES=16, STRETCH_CYCLES=8)
REQ-029 SHALL cover: rst_n low with random pads -> soc_rx=1, pad_tx=1, break_det=0, rx_led=0, tx_led=0, glitch_count=0.
REQ-030 SHALL cover: pad_rx low for 10 cycles -> soc_rx falls on edge 5; rx_led high for exactly 8 cycles from the next cycle; glitch_count stays 0.
REQ-031 SHALL cover: pad_rx low pulses of 1 and 2 cycles -> soc_rx stays 1; glitch_count = 2; 300 such pulses -> glitch_count = 255.
REQ-032 SHALL cover: pad_rx low for 40 cycles -> break_det rises 17 cycles after soc_rx falls; after pad_rx returns high, break_det falls 1 cycle after soc_rx rises.
REQ-033 SHALL cover: soc_tx 1->0->1 with 3-cycle spacing, repeated every 5 cycles -> pad_tx follows 1 cycle late; tx_led stays high continuously and falls 8 cycles after the last falling edge.
REQ-034 SHALL cover: rst_n pulsed low during the 2nd filter sample of a pad_rx low -> all outputs return to reset values at once; after release, soc_rx falls only after a full FILTER_LEN+2 edges.

Source files
------------

// File: rtl/fpga_uart_conditioner.sv
// rtl/fpga_uart_conditioner.sv - UART pad conditioner: RX sync/filter, TX register, break detect, activity LEDs
module fpga_uart_conditioner #(
  parameter int FILTER_LEN     = 3,
  parameter int BREAK_CYCLES   = 8192,
  parameter int STRETCH_CYCLES = 4194304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_rx,
  output logic       soc_rx,
  input  logic       soc_tx,
  output logic       pad_tx,
  output logic       break_det,
  output logic       rx_led,
  output logic       tx_led,
  output logic [7:0] glitch_count
);

  // Filter counter only ever holds 0..FILTER_LEN-1; keep at least one bit for FILTER_LEN = 1.
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int BW = $clog2(BREAK_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [BW-1:0] BREAK_MAX = BW'(BREAK_CYCLES);
  localparam logic [SW-1:0] STR_MAX   = SW'(STRETCH_CYCLES);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          soc_rx_q, soc_rx_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic [7:0]    glitch_q, glitch_d;
  logic          pad_tx_q, pad_tx_d;
  logic [BW-1:0] brk_cnt_q, brk_cnt_d;
  logic          break_det_q, break_det_d;
  logic [SW-1:0] rx_str_q, rx_str_d;
  logic [SW-1:0] tx_str_q, tx_str_d;
  logic          rx_led_q, rx_led_d;
  logic          tx_led_q, tx_led_d;
  logic          rx_fall;
  logic          tx_fall;

  // Synchroniser stages and TX retiming are plain pass-through registers.
  always_comb begin
    s1_d     = pad_rx;
    s2_d     = s1_q;
    pad_tx_d = soc_tx;
  end

  // Glitch filter: accept a new level after FILTER_LEN consecutive differing samples;
  // a differing run that collapses before acceptance is counted as a glitch.
  always_comb begin
    soc_rx_d  = soc_rx_q;
    flt_cnt_d = '0;
    glitch_d  = glitch_q;
    if (s2_q != soc_rx_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        soc_rx_d = ~soc_rx_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end else if ((flt_cnt_q != '0) && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // Break detection: count filtered-low cycles, flag once the count has saturated.
  always_comb begin
    brk_cnt_d   = brk_cnt_q;
    break_det_d = 1'b0;
    if (soc_rx_q) begin
      brk_cnt_d = '0;
    end else begin
      if (brk_cnt_q != BREAK_MAX) begin
        brk_cnt_d = brk_cnt_q + BW'(1);
      end
      break_det_d = (brk_cnt_q == BREAK_MAX);
    end
  end

  // Activity stretchers: a falling edge (start bit) reloads the full period, else count down.
  always_comb begin
    rx_fall  = soc_rx_q & ~soc_rx_d;
    tx_fall  = pad_tx_q & ~pad_tx_d;
    rx_str_d = rx_str_q;
    tx_str_d = tx_str_q;
    if (rx_fall) begin
      rx_str_d = STR_MAX;
    end else if (rx_str_q != '0) begin
      rx_str_d = rx_str_q - SW'(1);
    end
    if (tx_fall) begin
      tx_str_d = STR_MAX;
    end else if (tx_str_q != '0) begin
      tx_str_d = tx_str_q - SW'(1);
    end
    rx_led_d = (rx_str_d != '0);
    tx_led_d = (tx_str_d != '0);
  end

  // State registers; reset puts both lines at idle-high and clears all activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      soc_rx_q    <= 1'b1;
      flt_cnt_q   <= '0;
      glitch_q    <= '0;
      pad_tx_q    <= 1'b1;
      brk_cnt_q   <= '0;
      break_det_q <= 1'b0;
      rx_str_q    <= '0;
      tx_str_q    <= '0;
      rx_led_q    <= 1'b0;
      tx_led_q    <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      soc_rx_q    <= soc_rx_d;
      flt_cnt_q   <= flt_cnt_d;
      glitch_q    <= glitch_d;
      pad_tx_q    <= pad_tx_d;
      brk_cnt_q   <= brk_cnt_d;
      break_det_q <= break_det_d;
      rx_str_q    <= rx_str_d;
      tx_str_q    <= tx_str_d;
      rx_led_q    <= rx_led_d;
      tx_led_q    <= tx_led_d;
    end
  end

  // Outputs are driven straight from registers.
  always_comb begin
    soc_rx       = soc_rx_q;
    pad_tx       = pad_tx_q;
    break_det    = break_det_q;
    rx_led       = rx_led_q;
    tx_led       = tx_led_q;
    glitch_count = glitch_q;
  end

endmodule

// File: tb/tb_fpga_uart_conditioner.sv
// tb/tb_fpga_uart_conditioner.sv - self-checking bench for fpga_uart_conditioner
module tb_fpga_uart_conditioner;

  localparam int FL = 3;
  localparam int BC = 16;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad_rx = 1'b1;
  logic       soc_tx = 1'b1;
  logic       soc_rx;
  logic       pad_tx;
  logic       break_det;
  logic       rx_led;
  logic       tx_led;
  logic [7:0] glitch_count;

  int n_tests = 0;
  int n_fail  = 0;

  fpga_uart_conditioner #(
    .FILTER_LEN    (FL),
    .BREAK_CYCLES  (BC),
    .STRETCH_CYCLES(SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_rx      (pad_rx),
    .soc_rx      (soc_rx),
    .soc_tx      (soc_tx),
    .pad_tx      (pad_tx),
    .break_det   (break_det),
    .rx_led      (rx_led),
    .tx_led      (tx_led),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: line values tracked as histories/ages rather than counters.
  int m_s1, m_s2, m_soc, m_run, m_glitch;
  int m_zrun;      // consecutive filtered-low values ending at the latest one
  int m_rx_age;    // edges since last soc_rx fall (SC or more = none recent)
  int m_ptx, m_tx_age;
  int m_brk;
  int old_soc, old_ptx, samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1; m_s2 = 1; m_soc = 1; m_run = 0; m_glitch = 0;
      m_zrun = 0; m_rx_age = SC; m_ptx = 1; m_tx_age = SC; m_brk = 0;
    end else begin
      old_soc = m_soc;
      samp    = m_s2;
      m_brk   = (m_zrun >= BC + 1) ? 1 : 0;
      if (samp != m_soc) begin
        m_run++;
        if (m_run == FL) begin
          m_soc = 1 - m_soc;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(pad_rx);
      m_zrun = (m_soc == 1) ? 0 : ((m_zrun < 1000) ? m_zrun + 1 : m_zrun);
      if (old_soc == 1 && m_soc == 0) m_rx_age = 0;
      else if (m_rx_age < SC) m_rx_age++;
      old_ptx = m_ptx;
      m_ptx   = int'(soc_tx);
      if (old_ptx == 1 && m_ptx == 0) m_tx_age = 0;
      else if (m_tx_age < SC) m_tx_age++;
    end
  end

  // Every cycle, compare all outputs against the model.
  always @(posedge clk) begin
    #2;
    check("m_soc_rx", soc_rx, m_soc);
    check("m_pad_tx", pad_tx, m_ptx);
    check("m_break_det", break_det, m_brk);
    check("m_rx_led", rx_led, (m_rx_age < SC) ? 1 : 0);
    check("m_tx_led", tx_led, (m_tx_age < SC) ? 1 : 0);
    check("m_glitch_count", glitch_count, m_glitch);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int len);
    @(negedge clk);
    pad_rx = 1'b0;
    repeat (len) @(negedge clk);
    pad_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  int f, b, r, d, hi, first, last_fall, off_at, run_left;
  logic drv, prev_ptx;

  initial begin
    // Reset with random pads
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pad_rx = 1'($urandom);
      soc_tx = 1'($urandom);
    end
    step();
    check("rst_soc_rx", soc_rx, 1);
    check("rst_pad_tx", pad_tx, 1);
    check("rst_break_det", break_det, 0);
    check("rst_rx_led", rx_led, 0);
    check("rst_tx_led", tx_led, 0);
    check("rst_glitch", glitch_count, 0);

    // Clean release: nothing happens
    @(negedge clk);
    pad_rx = 1'b1; soc_tx = 1'b1; rst_n = 1'b1;
    repeat (10) step();
    check("rel_rx_led", rx_led, 0);
    check("rel_tx_led", tx_led, 0);
    check("rel_glitch", glitch_count, 0);

    // Ten-cycle low: accepted on edge 5, LED on for 8 cycles
    hi = 0; first = -1;
    @(negedge clk);
    pad_rx = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 4) check("acc_edge4_soc_rx", soc_rx, 1);
      if (e == 5) check("acc_edge5_soc_rx", soc_rx, 0);
      if (rx_led) begin
        hi++;
        if (first < 0) first = e;
      end
      if (e == 10) begin
        @(negedge clk);
        pad_rx = 1'b1;
      end
    end
    check("acc_led_first", first, 5);
    check("acc_led_width", hi, 8);
    check("acc_glitch", glitch_count, 0);

    // Short pulses are glitches; saturation at 255
    pulse(1);
    pulse(2);
    repeat (3) step();
    check("gl_soc_rx", soc_rx, 1);
    check("gl_two", glitch_count, 2);
    for (int i = 0; i < 300; i++) pulse(1 + (i % 2));
    repeat (3) step();
    check("gl_sat", glitch_count, 255);

    // Break: rise 17 after soc_rx falls, fall 1 after soc_rx rises
    f = -1; b = -1; r = -1; d = -1;
    @(negedge clk);
    pad_rx = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (f < 0 && !soc_rx) f = e;
      if (b < 0 && break_det) b = e;
    end
    @(negedge clk);
    pad_rx = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (r < 0 && soc_rx) r = e;
      if (d < 0 && !break_det) d = e;
    end
    check("brk_soc_fall_edge", f, 5);
    check("brk_rise_delay", b - f, 17);
    check("brk_fall_delay", d - r, 1);

    // TX activity: pulses every 5 cycles keep LED on
    last_fall = -1; off_at = -1; prev_ptx = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drv = (c < 30 && (c % 5) < 3) ? 1'b0 : 1'b1;
      soc_tx = drv;
      step();
      check("tx_latency", pad_tx, drv);
      if (prev_ptx && !pad_tx) last_fall = c;
      prev_ptx = pad_tx;
      if (last_fall >= 0 && off_at < 0 && !tx_led) off_at = c;
    end
    check("tx_last_fall", last_fall, 25);
    check("tx_led_off_delay", off_at - last_fall, 8);

    // Reset in the middle of filtering
    @(negedge clk);
    pad_rx = 1'b0; soc_tx = 1'b0;
    step(); step(); step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_soc_rx", soc_rx, 1);
    check("mid_rst_pad_tx", pad_tx, 1);
    check("mid_rst_break", break_det, 0);
    check("mid_rst_rx_led", rx_led, 0);
    check("mid_rst_tx_led", tx_led, 0);
    check("mid_rst_glitch", glitch_count, 0);
    repeat (2) @(negedge clk);
    soc_tx = 1'b1; rst_n = 1'b1;
    f = -1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (f < 0 && !soc_rx) f = e;
    end
    check("mid_rst_refilter", f, 5);
    @(negedge clk);
    pad_rx = 1'b1;
    repeat (10) step();

    // Randomized traffic against the model, with occasional resets
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (run_left == 0) begin
        pad_rx = ~pad_rx;
        run_left = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 30);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) soc_tx = ~soc_tx;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
